// File: rtl/alu_issue_if.sv
// Handshake bundle between the decoder, the ALU issue stage and the writeback path.
// The master modport is the environment side; the slave modport is the issue stage.
interface alu_issue_if #(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_ope;
  logic [NREG_LOG2-1:0] in_rd;
  logic [NREG_LOG2-1:0] in_rs;
  logic [NREG_LOG2-1:0] in_rt;
  logic [15:0]          in_imm;
  logic                 in_use_imm;
  logic                 wb_en;
  logic [NREG_LOG2-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_ope;
  logic [DATA_W-1:0]    out_ds;
  logic [DATA_W-1:0]    out_dt;
  logic [NREG_LOG2-1:0] out_rd;

  modport master (
    output in_valid, in_ope, in_rd, in_rs, in_rt, in_imm, in_use_imm,
    output wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_ope, out_ds, out_dt, out_rd
  );

  modport slave (
    input  in_valid, in_ope, in_rd, in_rs, in_rt, in_imm, in_use_imm,
    input  wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_ope, out_ds, out_dt, out_rd
  );
endinterface

// File: rtl/alu_issue.sv
// Operand-fetch/issue stage: register file, busy scoreboard with writeback bypass,
// and a registered {ope, ds, dt, rd} bundle towards the ALU.
module alu_issue #(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rstn,
  alu_issue_if.slave  bus
);
  localparam int NREG = 1 << NREG_LOG2;

  logic [DATA_W-1:0]    regs_q [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;
  logic [NREG-1:0]      busy_eff_s;
  logic                 out_valid_q;
  logic [2:0]           out_ope_q;
  logic [DATA_W-1:0]    out_ds_q;
  logic [DATA_W-1:0]    out_dt_q;
  logic [NREG_LOG2-1:0] out_rd_q;

  logic                 wb_hit_s;
  logic                 hz_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [DATA_W-1:0]    rs_val_s;
  logic [DATA_W-1:0]    rt_val_s;
  logic [DATA_W-1:0]    dt_val_s;

  // Register read with r0 hardwired to zero and same-cycle writeback forwarding.
  function automatic logic [DATA_W-1:0] read_fwd(
    input logic [NREG_LOG2-1:0] idx,
    input logic                 hit,
    input logic [NREG_LOG2-1:0] wb_idx,
    input logic [DATA_W-1:0]    wb_val,
    input logic [DATA_W-1:0]    reg_val
  );
    logic [DATA_W-1:0] res;
    if (idx == '0) begin
      res = '0;
    end else if (hit && (wb_idx == idx)) begin
      res = wb_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  assign wb_hit_s = bus.wb_en && (bus.wb_rd != '0);

  // Busy view after the same-cycle writeback clear; r0 is never busy.
  always_comb begin
    busy_eff_s = busy_q;
    if (wb_hit_s) begin
      busy_eff_s[bus.wb_rd] = 1'b0;
    end else begin
      busy_eff_s = busy_q;
    end
    busy_eff_s[0] = 1'b0;
  end

  assign rs_val_s = read_fwd(bus.in_rs, wb_hit_s, bus.wb_rd, bus.wb_data, regs_q[bus.in_rs]);
  assign rt_val_s = read_fwd(bus.in_rt, wb_hit_s, bus.wb_rd, bus.wb_data, regs_q[bus.in_rt]);

  assign hz_s = busy_eff_s[bus.in_rs]
              | (~bus.in_use_imm & busy_eff_s[bus.in_rt])
              | busy_eff_s[bus.in_rd];
  assign in_ready_s  = ~hz_s & (~out_valid_q | bus.out_ready);
  assign accept_s    = bus.in_valid & in_ready_s;
  assign bus.in_ready = in_ready_s;

  // Second operand: add/sub sign-extend the immediate, everything else zero-extends.
  always_comb begin
    dt_val_s = rt_val_s;
    if (bus.in_use_imm) begin
      case (bus.in_ope)
        3'b001, 3'b010: dt_val_s = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
        default:        dt_val_s = {{(DATA_W-16){1'b0}}, bus.in_imm};
      endcase
    end else begin
      dt_val_s = rt_val_s;
    end
  end

  // Scoreboard next state; a set from a new issue overrides a same-edge clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit_s) begin
      busy_d[bus.wb_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (accept_s && (bus.in_rd != '0)) begin
      busy_d[bus.in_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_hit_s) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Busy scoreboard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Issue bundle: load on accept, drop valid on retire, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_ope_q   <= 3'b000;
      out_ds_q    <= '0;
      out_dt_q    <= '0;
      out_rd_q    <= '0;
    end else if (accept_s) begin
      out_valid_q <= 1'b1;
      out_ope_q   <= bus.in_ope;
      out_ds_q    <= rs_val_s;
      out_dt_q    <= dt_val_s;
      out_rd_q    <= bus.in_rd;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ope   = out_ope_q;
  assign bus.out_ds    = out_ds_q;
  assign bus.out_dt    = out_dt_q;
  assign bus.out_rd    = out_rd_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios with literal expectations, then random
// traffic, all checked each cycle against an array-based reference model.
module tb_alu_issue;
  logic clk;
  logic rstn;
  int   pass_cnt;
  int   total_cnt;
  logic seen_ready;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_ov;
  logic [2:0]  m_ope;
  logic [31:0] m_ds;
  logic [31:0] m_dt;
  logic [4:0]  m_rd;

  alu_issue_if #(.DATA_W(32), .NREG_LOG2(5)) bus ();

  alu_issue #(.DATA_W(32), .NREG_LOG2(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
    m_ov   = 1'b0;
    m_ope  = 3'b000;
    m_ds   = 32'h0;
    m_dt   = 32'h0;
    m_rd   = 5'd0;
  endtask

  // Architectural value of a register as seen this cycle, writeback included.
  function automatic logic [31:0] mval(input logic [4:0] idx, input logic we,
                                       input logic [4:0] wrd, input logic [31:0] wdat);
    if (idx == 5'd0) return 32'h0;
    if (we && wrd == idx) return wdat;
    return m_regs[idx];
  endfunction

  function automatic logic mbusy(input logic [4:0] idx, input logic we, input logic [4:0] wrd);
    if (idx == 5'd0) return 1'b0;
    if (we && wrd == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  // One clock: drive, check in_ready, advance the model, check the bundle.
  task automatic cycle(input logic v, input logic [2:0] ope, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic ui, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wdat, input logic ordy);
    logic exp_ready;
    logic acc;
    logic [31:0] nds;
    logic [31:0] ndt;
    bus.in_valid = v;   bus.in_ope = ope; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_imm = imm;   bus.in_use_imm = ui;
    bus.wb_en = we;     bus.wb_rd = wrd;  bus.wb_data = wdat; bus.out_ready = ordy;
    #1;
    exp_ready = !(mbusy(rs, we, wrd) || (!ui && mbusy(rt, we, wrd)) || mbusy(rd, we, wrd))
                && (!m_ov || ordy);
    seen_ready = bus.in_ready;
    check32("in_ready", {31'h0, seen_ready}, {31'h0, exp_ready});
    acc = v && exp_ready;
    nds = mval(rs, we, wrd, wdat);
    if (ui) ndt = (ope == 3'b001 || ope == 3'b010) ? {{16{imm[15]}}, imm} : {16'h0, imm};
    else    ndt = mval(rt, we, wrd, wdat);
    if (acc) begin
      m_ov = 1'b1; m_ope = ope; m_rd = rd; m_ds = nds; m_dt = ndt;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (we && wrd != 5'd0) begin
      m_regs[wrd] = wdat;
      m_busy[wrd] = 1'b0;
    end
    if (acc && rd != 5'd0) m_busy[rd] = 1'b1;
    @(posedge clk);
    #1;
    check32("out_valid", {31'h0, bus.out_valid}, {31'h0, m_ov});
    if (m_ov) begin
      check32("out_ope", {29'h0, bus.out_ope}, {29'h0, m_ope});
      check32("out_ds", bus.out_ds, m_ds);
      check32("out_dt", bus.out_dt, m_dt);
      check32("out_rd", {27'h0, bus.out_rd}, {27'h0, m_rd});
    end
  endtask

  task automatic idle(input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    cycle(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, we, wrd, wdat, 1'b1);
  endtask

  initial begin
    logic [4:0]  wrd;
    logic [4:0]  busy_list [$];
    clk = 1'b0; rstn = 1'b0; pass_cnt = 0; total_cnt = 0;
    bus.in_valid = 1'b0; bus.in_ope = 3'b000; bus.in_rd = 5'd0; bus.in_rs = 5'd0;
    bus.in_rt = 5'd0; bus.in_imm = 16'h0; bus.in_use_imm = 1'b0; bus.wb_en = 1'b0;
    bus.wb_rd = 5'd0; bus.wb_data = 32'h0; bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check32("rst_out_ope", {29'h0, bus.out_ope}, 32'h0);
    check32("rst_out_ds", bus.out_ds, 32'h0);
    check32("rst_out_dt", bus.out_dt, 32'h0);
    check32("rst_out_rd", {27'h0, bus.out_rd}, 32'h0);
    rstn = 1'b1;

    idle(1'b1, 5'd1, 32'h0000_0005);
    idle(1'b1, 5'd2, 32'h0000_0003);
    cycle(1'b1, 3'b001, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("add_valid", {31'h0, bus.out_valid}, 32'h1);
    check32("add_ds", bus.out_ds, 32'h0000_0005);
    check32("add_dt", bus.out_dt, 32'h0000_0003);
    check32("add_rd", {27'h0, bus.out_rd}, 32'd3);
    cycle(1'b0, 3'b001, 5'd0, 5'd3, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("busy3_stall", {31'h0, seen_ready}, 32'h0);

    cycle(1'b1, 3'b001, 5'd6, 5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("imm_sext", bus.out_dt, 32'hFFFF_FFFF);
    cycle(1'b1, 3'b110, 5'd7, 5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("imm_zext", bus.out_dt, 32'h0000_FFFF);

    cycle(1'b1, 3'b001, 5'd4, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 3'b001, 5'd8, 5'd4, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
      check32("raw_stall", {31'h0, seen_ready}, 32'h0);
    end
    cycle(1'b1, 3'b001, 5'd8, 5'd4, 5'd0, 16'h0, 1'b1, 1'b1, 5'd4, 32'h0000_1234, 1'b1);
    check32("raw_bypass_ready", {31'h0, seen_ready}, 32'h1);
    check32("raw_bypass_ds", bus.out_ds, 32'h0000_1234);

    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 3'b011, 5'd9, 5'd1, 5'd0, 16'h0007, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      check32("bp_stall", {31'h0, seen_ready}, 32'h0);
      check32("bp_hold_rd", {27'h0, bus.out_rd}, 32'd8);
      check32("bp_hold_ds", bus.out_ds, 32'h0000_1234);
    end
    cycle(1'b1, 3'b011, 5'd9, 5'd1, 5'd0, 16'h0007, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("bp_release_valid", {31'h0, bus.out_valid}, 32'h1);
    check32("bp_release_rd", {27'h0, bus.out_rd}, 32'd9);
    check32("bp_release_dt", bus.out_dt, 32'h0000_0007);

    cycle(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 16'h0, 1'b1, 1'b1, 5'd5, 32'h0000_ABCD, 1'b1);
    check32("setclr_accept", {31'h0, seen_ready}, 32'h1);
    cycle(1'b0, 3'b001, 5'd0, 5'd5, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("setclr_busy", {31'h0, seen_ready}, 32'h0);

    cycle(1'b1, 3'b010, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD, 1'b1);
    check32("r0_ready", {31'h0, seen_ready}, 32'h1);
    check32("r0_ds", bus.out_ds, 32'h0);
    check32("r0_dt", bus.out_dt, 32'h0);
    cycle(1'b1, 3'b010, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("r0_never_busy", {31'h0, seen_ready}, 32'h1);

    for (int n = 0; n < 1500; n++) begin
      busy_list.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) busy_list.push_back(5'(i));
      if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
        wrd = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        wrd = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wrd, $urandom,
            1'($urandom_range(0, 3) != 0));
    end

    idle(1'b1, 5'd10, 32'h0);
    cycle(1'b1, 3'b100, 5'd10, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(1'b0, 3'b100, 5'd10, 5'd10, 5'd10, 16'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    check32("pre_rst_stall", {31'h0, seen_ready}, 32'h0);
    check32("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check32("async_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check32("async_rst_ds", bus.out_ds, 32'h0);
    check32("async_rst_busy_clear", {31'h0, bus.in_ready}, 32'h1);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle(1'b1, 3'b001, 5'd11, 5'd10, 5'd0, 16'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    check32("post_rst_reg_zero", bus.out_ds, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Operand-fetch/issue stage directly upstream of the integer ALU. Accepts decoded ALU instructions and holds the 32x32 integer register file. Tracks in-flight destinations with a per-register busy scoreboard and stalls on RAW/WAW hazards. Presents a registered {ope, ds, dt, rd} bundle to the ALU over a valid/ready handshake; writeback from the ALU/writeback stage returns through the wb_* port.

Parameters:
DATA_W, 32, register and operand width
NREG_LOG2, 5, register index width (2**NREG_LOG2 registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle when in_valid && in_ready
in_ope  input  3  ALU opcode (001 add, 010 sub, 011 sll, 100 srl, 101 sra, 110 lui)
in_rd  input  5  destination register
in_rs  input  5  source register for ds
in_rt  input  5  source register for dt (ignored when in_use_imm=1)
in_imm  input  16  immediate
in_use_imm  input  1  1: dt from immediate; 0: dt from rt
wb_en  input  1  register write strobe
wb_rd  input  5  write register index
wb_data  input  32  write data
out_valid  output  1  issue bundle valid
out_ready  input  1  ALU side accepts bundle
out_ope  output  3  registered opcode
out_ds  output  32  registered first operand
out_dt  output  32  registered second operand
out_rd  output  5  registered destination

Behaviour:
- Reset (asynchronous, rstn=0): all registers=0, all busy bits=0, out_valid=0, out_ope=0, out_ds=0, out_dt=0, out_rd=0. Any in-flight bundle is dropped.
- r0: reads return 0, never busy, writes ignored (wb_rd=0 or in_rd=0 sets nothing).
- Register write: on wb_en && wb_rd!=0, reg[wb_rd]<=wb_data and busy[wb_rd]<=0. Writes to a non-busy register still update it.
- Bypass: same-cycle read of wb_rd (wb_en=1, wb_rd!=0) returns wb_data and treats that register as not busy.
- Hazard: hz = (busy'[rs]) || (!in_use_imm && busy'[rt]) || busy'[rd], where busy' is busy after same-cycle wb clear; index 0 never hazardous.
- in_ready = !hz && (!out_valid || out_ready). Combinational; in_ready may be 1 while in_valid=0.
- Accept (in_valid && in_ready): next edge latches out_ope=in_ope, out_rd=in_rd, out_ds=rs value, out_valid=1. If in_rd!=0, sets busy[in_rd]=1.
- dt selection: in_use_imm=0 gives the rt value. in_use_imm=1 gives sign-extended imm for ope 001/010, and zero-extended imm for all other opcodes.
- Same-edge set and clear of one busy bit (accept with in_rd=X, wb_rd=X): set wins, busy stays 1.
- Output handshake: bundle holds stable while out_valid && !out_ready. The bundle retires when out_valid && out_ready; out_valid goes to 0 unless a new instruction is accepted on the same edge.
- Latency: one cycle from acceptance to out_valid. Full throughput (one/cycle) for independent instructions with out_ready=1.
- Dependent back-to-back instruction stalls until the producer's wb_en arrives; issue is allowed in the wb cycle itself via the bypass.
- Unknown opcodes (000, 111) pass through unchanged; this stage performs no opcode checking.

Test Plan:
- Reset then wb_en writes r1=0x0000_0005, r2=0x0000_0003; issue ope=001 rd=3 rs=1 rt=2 -> next cycle out_valid=1, out_ds=5, out_dt=3, out_rd=3, busy[3]=1.
- Immediate extension: rs=0, imm=0xFFFF, use_imm=1, ope=001 -> out_dt=0xFFFF_FFFF. Same inputs with ope=110 -> out_dt=0x0000_FFFF.
- RAW stall: issue rd=4, then rs=4 -> in_ready=0 until the wb_en rd=4 data=0x1234 cycle, in which in_ready=1 and the latched out_ds=0x1234.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> bundle unchanged and in_ready=0. On out_ready=1, a new independent instruction is accepted on the same edge and out_valid stays 1.
- Same-edge set/clear: busy[5]=1, wb rd=5 and accept rd=5 in one cycle -> busy[5]=1 afterwards and reg[5]=wb_data. Write to r0 -> reads still 0, never stalls.
- Reset mid-operation: rstn=0 asynchronously while out_valid=1 and busy bits set -> out_valid=0 and all busy=0 immediately, without waiting for a clock edge.
